pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised elastic pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It replaces fixed-field, stall-driven stage registers: upstream backpressure is carried by a registered ready instead of a global stall. It supports flush, which clears the stage, and per-transfer kill, which drops the instruction. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB); the caller packs that boundary's fields into the data and control vectors.

## Interface
Parameters:
- DATA_W, default 101: data payload width (e.g. pc + alu_result + store_data + rd).
- CTRL_W, default 9: control payload width (mem_read, mem_write, wb_en, mispred, is_control, funct3, …).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-low reset.
- i_flush  in  1  synchronous clear of both entries; wins over every handshake.
- i_valid  in  1  upstream item present.
- o_ready  out  1  stage can accept; registered.
- i_kill  in  1  qualifies i_valid; the accepted item is discarded, not stored.
- i_data  in  DATA_W  data payload.
- i_ctrl  in  CTRL_W  control payload.
- o_valid  out  1  o_data/o_ctrl hold a live item.
- i_ready  in  1  downstream accepts.
- o_data  out  DATA_W  head item data.
- o_ctrl  out  CTRL_W  head item control.
- o_count  out  2  occupancy, 0..2.

## Operation
- Accept: i_valid && o_ready && !i_kill. Drop: i_valid && o_ready && i_kill (handshake completes, nothing stored). Emit: o_valid && i_ready.
- Storage: the main register drives the outputs. The skid register holds a second item. Order is preserved: the main register always holds the older item.
- States (pipe_pkg enum): EMPTY (count 0), ONE (count 1), TWO (count 2).
  - EMPTY: accept → ONE, main ← input.
  - ONE: accept and emit → ONE, main ← input. Accept only → TWO, skid ← input. Emit only → EMPTY. Neither → hold.
  - TWO: o_ready = 0, so no accept is possible. Emit → ONE, main ← skid. Otherwise hold.
- A drop behaves as "no accept" for the state transitions.
- o_ready = (next state != TWO), registered. It depends on no input combinationally.
- o_valid = (state != EMPTY).
- Flush: next state EMPTY, o_valid = 0, o_ready = 1 on the following cycle. Any input presented in the flush cycle is discarded. A downstream emit in the flush cycle still counts downstream.
- Reset (i_reset = 0): state EMPTY, o_valid 0, o_ready 1, o_count 0, o_data 0, o_ctrl 0, skid 0. i_valid during reset is ignored.
- Priority: reset > flush > handshakes.

## Timing
- Latency: an item accepted at edge N is visible on o_data/o_ctrl with o_valid = 1 after edge N.
- Throughput: 1 item/cycle while i_ready = 1. A bubble is never inserted when the input is continuous.
- Backpressure: while o_valid && !i_ready, o_data/o_ctrl/o_valid hold stable (AXI-style).
- After i_ready falls, at most one more item is accepted (it goes into skid). o_ready falls on the edge that fills skid.
- From TWO, i_ready = 1 for one cycle → ONE, with o_ready = 1 on the next cycle. Full throughput resumes with no lost or duplicated item.
- Reset released mid-operation: all contents are lost. The first accept is possible on the cycle after i_reset returns high.

## Configuration
- PIPE_STAGE_ZERO_BUBBLE_EN defined:
  - Every entry that becomes empty (by emit, drop, flush or reset) has its data and ctrl cleared to 0.
  - o_data and o_ctrl read 0 whenever o_valid = 0.
  - Guarantees that no stale write-enable or mem-write bit leaks to consumers that ignore valid.
- Undefined: empty entries keep stale payload. o_data and o_ctrl are don't-care while o_valid = 0, which saves area and power.

## Structure
- pipe_pkg holds:
  - the state enum pipe_skid_state_e (EMPTY/ONE/TWO);
  - the occupancy width constant PIPE_CNT_W = 2;
  - the per-boundary packed field widths used by callers to size DATA_W and CTRL_W.
- No sub-module: both entries are plain registers on the concatenated {ctrl, data} vector, plus the next-state logic.

## Test plan
- Streaming: i_ready = 1, 8 consecutive items with data 0x1..0x8 → o_data 0x1..0x8 on consecutive cycles one cycle later; o_count stays 1; o_ready stays 1.
- Backpressure:
  - Hold i_ready = 0 while feeding 0xA, 0xB, 0xC → o_ready drops after 0xB; 0xC is not accepted; o_data holds 0xA; o_count = 2.
  - Release i_ready → outputs 0xA, 0xB, 0xC in order with no duplicate.
- Kill: feed 0x10, killed 0x11, then 0x12 → outputs 0x10 then 0x12; o_count never exceeds 1.
- Flush while in TWO (0x20 and 0x21 stored, 0x22 presented) → next cycle o_valid = 0, o_count = 0, o_ready = 1; 0x22 is never emitted.
- Reset mid-stream, i_reset = 0 for one cycle → o_valid 0, o_ready 1, o_data 0; the next item is accepted normally.
- With PIPE_STAGE_ZERO_BUBBLE_EN: after the last emit, o_data = 0 and o_ctrl = 0. Without it, o_data keeps the last value.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and widths for the elastic pipeline stage register (pipe_stage_skid).
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_skid_state_e;

   localparam int PIPE_CNT_W = 2;

   // Per-boundary payload widths callers use to size DATA_W / CTRL_W
   localparam int IF_ID_DATA_W  = 64;   // pc + instr
   localparam int IF_ID_CTRL_W  = 1;    // mispred
   localparam int ID_EX_DATA_W  = 133;  // pc + rs1 + rs2 + imm + rd
   localparam int ID_EX_CTRL_W  = 9;
   localparam int EX_MEM_DATA_W = 101;  // pc + alu_result + store_data + rd
   localparam int EX_MEM_CTRL_W = 9;    // mem_read, mem_write, wb_en, mem_to_reg, mispred, is_control, funct3
   localparam int MEM_WB_DATA_W = 69;   // pc + result + rd
   localparam int MEM_WB_CTRL_W = 1;    // wb_en

   function automatic logic [PIPE_CNT_W-1:0] pipe_count(input pipe_skid_state_e s);
      case (s)
         ONE:     return 2'd1;
         TWO:     return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Elastic stage register with a 2-entry skid buffer and registered upstream ready.
// Optional PIPE_STAGE_ZERO_BUBBLE_EN zeroes every entry that becomes empty.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W = 101,
   parameter int CTRL_W = 9
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_flush,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_kill,
   input  logic [DATA_W-1:0]     i_data,
   input  logic [CTRL_W-1:0]     i_ctrl,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_W-1:0]     o_data,
   output logic [CTRL_W-1:0]     o_ctrl,
   output logic [PIPE_CNT_W-1:0] o_count
);

   localparam int ENTRY_W = DATA_W + CTRL_W;

`ifdef PIPE_STAGE_ZERO_BUBBLE_EN
   localparam bit ZERO_BUBBLE = 1'b1;
`else
   localparam bit ZERO_BUBBLE = 1'b0;
`endif

   pipe_skid_state_e    r_state;
   pipe_skid_state_e    w_nextState;
   logic                r_ready;
   logic [ENTRY_W-1:0]  r_main;
   logic [ENTRY_W-1:0]  r_skid;
   logic [ENTRY_W-1:0]  w_in;
   logic                w_accept;
   logic                w_emit;
   logic                w_mainLoadIn;
   logic                w_mainLoadSkid;
   logic                w_skidLoadIn;
   logic                w_mainRelease;
   logic                w_skidRelease;

   assign w_in     = {i_ctrl, i_data};
   assign w_accept = i_valid && r_ready && !i_kill;
   assign w_emit   = (r_state != EMPTY) && i_ready;

   // Ready is the registered image of "next state is not full"
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= EMPTY;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_nextState;
         r_ready <= (w_nextState != TWO);
      end
   end

   always_comb begin
      w_nextState    = r_state;
      w_mainLoadIn   = 1'b0;
      w_mainLoadSkid = 1'b0;
      w_skidLoadIn   = 1'b0;
      w_mainRelease  = 1'b0;
      w_skidRelease  = 1'b0;
      if (i_flush) begin
         w_nextState   = EMPTY;
         w_mainRelease = 1'b1;
         w_skidRelease = 1'b1;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  w_nextState  = ONE;
                  w_mainLoadIn = 1'b1;
               end
            end
            ONE: begin
               if (w_accept && w_emit) begin
                  w_mainLoadIn = 1'b1;
               end else if (w_accept) begin
                  w_nextState  = TWO;
                  w_skidLoadIn = 1'b1;
               end else if (w_emit) begin
                  w_nextState   = EMPTY;
                  w_mainRelease = 1'b1;
               end
            end
            TWO: begin
               if (w_emit) begin
                  w_nextState    = ONE;
                  w_mainLoadSkid = 1'b1;
                  w_skidRelease  = 1'b1;
               end
            end
            default: w_nextState = EMPTY;
         endcase
      end
   end

   // Main always holds the older item; skid only ever fills from the input
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_mainLoadIn)
            r_main <= w_in;
         else if (w_mainLoadSkid)
            r_main <= r_skid;
         else if (ZERO_BUBBLE && w_mainRelease)
            r_main <= '0;

         if (w_skidLoadIn)
            r_skid <= w_in;
         else if (ZERO_BUBBLE && w_skidRelease)
            r_skid <= '0;
      end
   end

   always_comb begin
      o_ready          = r_ready;
      o_valid          = (r_state != EMPTY);
      o_count          = pipe_count(r_state);
      {o_ctrl, o_data} = r_main;
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid against a queue-based reference model.
module tb_pipe_stage_skid;

   localparam int DW = 101;
   localparam int CW = 9;
   localparam int EW = DW + CW;

`ifdef PIPE_STAGE_ZERO_BUBBLE_EN
   localparam bit ZB = 1'b1;
`else
   localparam bit ZB = 1'b0;
`endif

   typedef logic [EW-1:0] item_t;

   logic          clk    = 1'b0;
   logic          rstN   = 1'b0;
   logic          flush  = 1'b0;
   logic          iValid = 1'b0;
   logic          iKill  = 1'b0;
   logic          iReady = 1'b0;
   logic [DW-1:0] iData  = '0;
   logic [CW-1:0] iCtrl  = '0;
   logic          oReady;
   logic          oValid;
   logic [DW-1:0] oData;
   logic [CW-1:0] oCtrl;
   logic [1:0]    oCount;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW)) dut (
      .i_clk   (clk),
      .i_reset (rstN),
      .i_flush (flush),
      .i_valid (iValid),
      .o_ready (oReady),
      .i_kill  (iKill),
      .i_data  (iData),
      .i_ctrl  (iCtrl),
      .o_valid (oValid),
      .i_ready (iReady),
      .o_data  (oData),
      .o_ctrl  (oCtrl),
      .o_count (oCount)
   );

   // Reference: FIFO of at most two items plus the registered ready it implies
   item_t q[$];
   logic  mReady   = 1'b1;
   item_t lastHead = '0;
   int    total    = 0;
   int    bad      = 0;

   task automatic checkVal(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      item_t expHead;
      if (q.size() > 0)
         expHead = q[0];
      else
         expHead = ZB ? '0 : lastHead;
      checkVal("valid", EW'(oValid), EW'(q.size() > 0));
      checkVal("ready", EW'(oReady), EW'(mReady));
      checkVal("count", EW'(oCount), EW'(q.size()));
      checkVal("data",  EW'(oData),  EW'(expHead[DW-1:0]));
      checkVal("ctrl",  EW'(oCtrl),  EW'(expHead[EW-1:DW]));
   endtask

   task automatic modelEdge();
      bit em;
      bit ac;
      if (!rstN) begin
         q.delete();
         mReady   = 1'b1;
         lastHead = '0;
      end else begin
         if (q.size() > 0)
            lastHead = q[0];
         if (flush) begin
            q.delete();
         end else begin
            em = (q.size() > 0) && iReady;
            ac = iValid && mReady && !iKill;
            if (em)
               void'(q.pop_front());
            if (ac)
               q.push_back({iCtrl, iData});
         end
         mReady = (q.size() < 2);
      end
   endtask

   task automatic applyStimulus(input bit v, input bit k, input item_t it,
                                input bit r, input bit f, input bit n);
      iValid = v;
      iKill  = k;
      {iCtrl, iData} = it;
      iReady = r;
      flush  = f;
      rstN   = n;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkOutput();
   endtask

   function automatic item_t mk(input int v);
      return item_t'(v);
   endfunction

   initial begin
      @(negedge clk);
      applyStimulus(1, 0, mk(5), 1, 0, 0);
      applyStimulus(0, 0, mk(0), 0, 0, 0);

      // Streaming at full rate
      for (int i = 1; i <= 8; i++)
         applyStimulus(1, 0, mk(i), 1, 0, 1);
      applyStimulus(0, 0, mk(0), 1, 0, 1);

      // Backpressure fills skid, then drains in order
      applyStimulus(1, 0, mk('hA), 0, 0, 1);
      applyStimulus(1, 0, mk('hB), 0, 0, 1);
      applyStimulus(1, 0, mk('hC), 0, 0, 1);
      applyStimulus(1, 0, mk('hC), 0, 0, 1);
      applyStimulus(1, 0, mk('hC), 1, 0, 1);
      applyStimulus(1, 0, mk('hC), 1, 0, 1);
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 0, mk(0), 1, 0, 1);

      // Kill drops the middle item
      applyStimulus(1, 0, mk('h10), 1, 0, 1);
      applyStimulus(1, 1, mk('h11), 1, 0, 1);
      applyStimulus(1, 0, mk('h12), 1, 0, 1);
      applyStimulus(0, 0, mk(0), 1, 0, 1);
      applyStimulus(0, 0, mk(0), 1, 0, 1);

      // Flush while full
      applyStimulus(1, 0, mk('h20), 0, 0, 1);
      applyStimulus(1, 0, mk('h21), 0, 0, 1);
      applyStimulus(1, 0, mk('h22), 0, 1, 1);
      applyStimulus(0, 0, mk(0), 1, 0, 1);
      applyStimulus(0, 0, mk(0), 1, 0, 1);

      // Reset mid-stream, then a normal accept
      applyStimulus(1, 0, mk('h30), 0, 0, 1);
      applyStimulus(1, 0, mk('h31), 0, 0, 1);
      applyStimulus(1, 0, mk('h32), 1, 0, 0);
      applyStimulus(1, 0, mk('h33), 1, 0, 1);
      applyStimulus(0, 0, mk(0), 1, 0, 1);
      applyStimulus(0, 0, mk(0), 1, 0, 1);

      // Randomised traffic with occasional kill, flush and reset
      for (int i = 0; i < 600; i++) begin
         item_t it;
         it = item_t'({$urandom, $urandom, $urandom, $urandom});
         applyStimulus($urandom_range(0, 99) < 70,
                       $urandom_range(0, 99) < 10,
                       it,
                       $urandom_range(0, 99) < 60,
                       $urandom_range(0, 99) < 3,
                       $urandom_range(0, 99) >= 2);
      end
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 0, mk(0), 1, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
